seg7_digit_accumulator: RTL and testbench
=========================================

// Module: seg7_digit_accumulator
// PURPOSE
//  Receive side of the display path: takes a stream of 7-segment digit codes (keypad/bus echo of the display
//  encoding), decodes each code to a decimal digit and accumulates the digits MSD-first into a binary value.
//  It is the inverse of the binary->BCD->7-seg translators. It sits between the digit-entry front end and the
//  arithmetic core, which consumes num_out.
// PARAMETERS
//  MAX_DIGITS  4   digits accepted before FULL; result range 0..10^MAX_DIGITS-1
//  OUT_W       16  width of num_out; must hold 10^MAX_DIGITS-1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  seg_in     in   [0:6]  segment code, bit0=a..bit6=g, active-low (0=lit)
//  seg_valid  in   1      seg_in valid; digit accepted when seg_valid & seg_ready
//  seg_ready  out  1      block can accept a digit
//  commit     in   1      end of entry: publish accumulated value
//  clear      in   1      discard entry, return to IDLE
//  num_out    out  OUT_W  committed binary value, held until next commit
//  done       out  1      1-cycle pulse: num_out updated
//  digit_cnt  out  3      digits held in current entry (0..MAX_DIGITS)
//  err        out  1      1-cycle pulse: illegal code rejected
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, acc=0, num_out=0, digit_cnt=0, done=0, err=0, seg_ready=1.
//  Code table (seg_in -> digit): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5 0100000=6
//   0001111=7 0000000=8 0001100=9. Any other code (incl. blank 1111111) is illegal.
//  States: IDLE (no digits), ACCUM (1..MAX_DIGITS-1 digits), FULL (MAX_DIGITS digits), DONE (1 cycle).
//  Digit accept (seg_valid & seg_ready, legal code): acc <= acc*10 + d, computed (acc<<3)+(acc<<1)+d in
//   one cycle; digit_cnt+1; IDLE->ACCUM; ->FULL when digit_cnt reaches MAX_DIGITS.
//  Illegal code with seg_valid & seg_ready: acc/digit_cnt unchanged, err=1 next cycle, state unchanged.
//  seg_ready = (state==IDLE || state==ACCUM); 0 in FULL and DONE. seg_valid while !seg_ready is ignored.
//  Leading zeros count as digits (0,0,7 -> acc=7, digit_cnt=3).
//  commit in IDLE/ACCUM/FULL: num_out <= acc (zero-extended), done=1 next cycle, state->DONE, then IDLE
//   with acc=0, digit_cnt=0. commit in IDLE publishes 0. commit in DONE ignored.
//  Latency: digit accepted at edge N -> acc/digit_cnt valid after edge N; commit at edge N -> num_out and
//   done visible after edge N, done low after edge N+1.
//  Priority same cycle: rst_n > clear > commit > digit. clear: acc=0, digit_cnt=0, state=IDLE, num_out
//   unchanged, no done. commit+digit same cycle: digit dropped, pre-existing acc committed.
//  Reset mid-entry discards acc and zeroes num_out. No wrap-around possible: FULL blocks further digits.
// STRUCTURE
//  Package seg7_pkg: SEG_0..SEG_9, SEG_BLANK constants ([0:6], active-low); state enum
//   {S_IDLE,S_ACCUM,S_FULL,S_DONE}; shared with the encoder side so tables cannot diverge.
//  Sub-module seg7_to_digit: purely combinational, seg_in -> {legal, digit[3:0]}.
//  Top: FSM, accumulator register, shift-add multiply, output registers.
// TESTING
//  1. Reset, send codes 1,2,3,4 (1001111,0010010,0000110,1001100), commit -> num_out=1234, done 1 cycle, digit_cnt back to 0.
//  2. Send 9,9,9,9 then 5th digit 0000001 -> seg_ready=0 after 4th, 5th ignored; commit -> num_out=9999.
//  3. Send 1111111 then 0000010 -> err pulses twice, digit_cnt=0; then 0100100, commit -> num_out=5.
//  4. Send 7,8, assert clear -> digit_cnt=0, num_out keeps previous value, no done; commit -> num_out=0.
//  5. Send 3, then commit with seg_valid(6) same cycle -> num_out=3, digit 6 dropped.
//  6. Send 4,2, drop rst_n for 1 cycle -> num_out=0, digit_cnt=0, seg_ready=1; commit -> num_out=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions (active-low, bit0=a .. bit6=g) and accumulator state encoding.
// The encoder and decoder sides both import this package so their code tables stay identical.
package seg7_pkg;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0001100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Indexed by digit value so decoders can scan it.
    localparam logic [0:6] SEG_TABLE [10] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FULL  = 2'd2,
        S_DONE  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational 7-segment code to decimal digit decoder; legal_o is low for any code
// outside the ten digit patterns (including blank).
module seg7_to_digit
    import seg7_pkg::*;
(
    input  logic [0:6] seg_i,
    output logic       legal_o,
    output logic [3:0] digit_o
);

    logic [9:0] match;

    for (genvar gi = 0; gi < 10; gi++) begin : g_match
        assign match[gi] = (seg_i == SEG_TABLE[gi]);
    end

    // Codes are distinct, so at most one match bit is set.
    always_comb begin
        digit_o = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (match[i]) begin
                digit_o = 4'(i);
            end
        end
    end

    assign legal_o = |match;

endmodule

// File: rtl/seg7_digit_accumulator.sv
// Accumulates a stream of 7-segment digit codes MSD-first into a binary value and
// publishes it on commit. Priority: reset > clear > commit > digit.
module seg7_digit_accumulator
    import seg7_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int OUT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:6]       seg_in,
    input  logic             seg_valid,
    output logic             seg_ready,
    input  logic             commit,
    input  logic             clear,
    output logic [OUT_W-1:0] num_out,
    output logic             done,
    output logic [2:0]       digit_cnt,
    output logic             err
);

    acc_state_e       state_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic [OUT_W-1:0] num_q;
    logic [2:0]       cnt_q;
    logic [2:0]       cnt_d;
    logic             done_q;
    logic             err_q;
    logic             legal;
    logic [3:0]       digit;
    logic             accept;

    seg7_to_digit u_dec (
        .seg_i   (seg_in),
        .legal_o (legal),
        .digit_o (digit)
    );

    // acc*10 + d without a multiplier; FULL guarantees acc < 10^(MAX_DIGITS-1) here.
    assign acc_d  = (acc_q << 3) + (acc_q << 1) + {{(OUT_W-4){1'b0}}, digit};
    assign cnt_d  = cnt_q + 3'd1;
    assign accept = seg_valid && seg_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (commit && state_q != S_DONE) begin
                num_q   <= acc_q;
                done_q  <= 1'b1;
                state_q <= S_DONE;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_ACCUM: begin
                        if (accept && legal) begin
                            acc_q   <= acc_d;
                            cnt_q   <= cnt_d;
                            state_q <= (cnt_d == 3'(MAX_DIGITS)) ? S_FULL : S_ACCUM;
                        end else if (accept) begin
                            err_q <= 1'b1;
                        end
                    end
                    S_FULL: state_q <= S_FULL;
                    S_DONE: begin
                        state_q <= S_IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign seg_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign num_out   = num_q;
    assign done      = done_q;
    assign digit_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seg7_digit_accumulator.sv
// Directed bench for seg7_digit_accumulator: digit entry, FULL blocking, illegal codes,
// clear, commit/digit collision and mid-entry reset, against hand-computed values.
module tb_seg7_digit_accumulator;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:6]  seg_in;
    logic        seg_valid;
    logic        seg_ready;
    logic        commit;
    logic        clear;
    logic [15:0] num_out;
    logic        done;
    logic [2:0]  digit_cnt;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_digit_accumulator #(.MAX_DIGITS(4), .OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .commit    (commit),
        .clear     (clear),
        .num_out   (num_out),
        .done      (done),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One-cycle digit presentation; outputs sampled 1 ns after the accepting edge.
    task automatic send(input logic [0:6] code);
        @(negedge clk);
        seg_in    = code;
        seg_valid = 1'b1;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_in    = SEG_BLANK;
    endtask

    task automatic do_commit(input string tag, input logic [15:0] exp_num);
        @(negedge clk);
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
        check_eq({tag, " num_out"}, 32'(num_out), 32'(exp_num));
        check_eq({tag, " done"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check_eq({tag, " done low"}, 32'(done), 32'd0);
        check_eq({tag, " digit_cnt"}, 32'(digit_cnt), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; seg_in = SEG_BLANK; seg_valid = 1'b0; commit = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst num_out", 32'(num_out), 32'd0);
        check_eq("rst digit_cnt", 32'(digit_cnt), 32'd0);
        check_eq("rst seg_ready", 32'(seg_ready), 32'd1);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 1,2,3,4 -> 1234
        send(SEG_1); send(SEG_2); send(SEG_3);
        check_eq("t1 cnt3", 32'(digit_cnt), 32'd3);
        send(SEG_4);
        do_commit("t1", 16'd1234);

        // 2: four 9s fill the entry; fifth digit ignored
        send(SEG_9); send(SEG_9); send(SEG_9); send(SEG_9);
        check_eq("t2 ready full", 32'(seg_ready), 32'd0);
        check_eq("t2 cnt4", 32'(digit_cnt), 32'd4);
        send(SEG_0);
        check_eq("t2 cnt after 5th", 32'(digit_cnt), 32'd4);
        check_eq("t2 no err", 32'(err), 32'd0);
        do_commit("t2", 16'd9999);

        // 3: illegal codes pulse err and leave count alone
        send(SEG_BLANK);
        check_eq("t3 err blank", 32'(err), 32'd1);
        send(7'b0000010);
        check_eq("t3 err bad", 32'(err), 32'd1);
        check_eq("t3 cnt", 32'(digit_cnt), 32'd0);
        send(SEG_5);
        check_eq("t3 err clr", 32'(err), 32'd0);
        do_commit("t3", 16'd5);

        // 4: clear discards entry without touching num_out
        send(SEG_7); send(SEG_8);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_eq("t4 cnt", 32'(digit_cnt), 32'd0);
        check_eq("t4 num kept", 32'(num_out), 32'd5);
        check_eq("t4 no done", 32'(done), 32'd0);
        do_commit("t4", 16'd0);

        // 5: commit wins over a same-cycle digit
        send(SEG_3);
        @(negedge clk);
        seg_in = SEG_6; seg_valid = 1'b1; commit = 1'b1;
        @(posedge clk);
        #1;
        seg_valid = 1'b0; commit = 1'b0; seg_in = SEG_BLANK;
        check_eq("t5 num_out", 32'(num_out), 32'd3);
        check_eq("t5 done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check_eq("t5 cnt", 32'(digit_cnt), 32'd0);

        // 6: mid-entry reset zeroes everything
        send(SEG_4); send(SEG_2);
        check_eq("t6 cnt2", 32'(digit_cnt), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("t6 num_out", 32'(num_out), 32'd0);
        check_eq("t6 cnt", 32'(digit_cnt), 32'd0);
        check_eq("t6 ready", 32'(seg_ready), 32'd1);
        do_commit("t6", 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
